// File: rtl/latch_pkg.sv
// rtl/latch_pkg.sv - shared types, default timing and rail-pair decode for the latch writer
package latch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        SETTLE,
        CHECK
    } lw_state_t;

    localparam int SETUP_CYC_DEF  = 2;
    localparam int PULSE_CYC_DEF  = 4;
    localparam int HOLD_CYC_DEF   = 2;
    localparam int SETTLE_CYC_DEF = 3;
    localparam int CNT_W_DEF      = 8;

    typedef struct packed {
        logic valid;
        logic value;
    } rail_t;

    // Complementary rails: a legal pair has exactly one rail high; q0 carries the bit.
    function automatic rail_t rail_decode(input logic q0, input logic q1);
        rail_t r;
        r.valid = q0 ^ q1;
        r.value = q0;
        return r;
    endfunction

endpackage

// File: rtl/latch_write_ctrl_if.sv
// rtl/latch_write_ctrl_if.sv - request handshake, latch pins and status bundle
// master: the write controller; slave: request source plus latch cell
interface latch_write_ctrl_if;
    logic req_valid;
    logic req_data;
    logic req_ready;
    logic lat_d;
    logic lat_e;
    logic lat_q0;
    logic lat_q1;
    logic busy;
    logic done;
    logic err;

    modport master (
        input  req_valid, req_data, lat_q0, lat_q1,
        output req_ready, lat_d, lat_e, busy, done, err
    );

    modport slave (
        output req_valid, req_data, lat_q0, lat_q1,
        input  req_ready, lat_d, lat_e, busy, done, err
    );
endinterface

// File: rtl/latch_write_ctrl_sync2.sv
// rtl/latch_write_ctrl_sync2.sv - 1-bit two-flop synchroniser, async active-low reset to 0
// ports: clk, rst_n, d (asynchronous input), q (synchronised output)
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end
endmodule

// File: rtl/latch_write_ctrl.sv
// rtl/latch_write_ctrl.sv - sequences setup/pulse/hold/settle around a gated D-latch write and checks readback
// ports: clk, rst_n (async active-low); bus (master): req_valid/req_data/req_ready handshake,
//        lat_d/lat_e latch pins, lat_q0/lat_q1 readback rails, busy/done/err status
module latch_write_ctrl
    import latch_pkg::*;
#(
    parameter int SETUP_CYC  = SETUP_CYC_DEF,
    parameter int PULSE_CYC  = PULSE_CYC_DEF,
    parameter int HOLD_CYC   = HOLD_CYC_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input logic               clk,
    input logic               rst_n,
    latch_write_ctrl_if.master bus
);

    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);

    lw_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dreg_q, dreg_d;
    logic             lat_d_q, lat_d_d;
    logic             lat_e_q, lat_e_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             q0_s, q1_s;
    rail_t            rd;

    sync2 u_sync_q0 (.clk(clk), .rst_n(rst_n), .d(bus.lat_q0), .q(q0_s));
    sync2 u_sync_q1 (.clk(clk), .rst_n(rst_n), .d(bus.lat_q1), .q(q1_s));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dreg_d  = dreg_q;
        done_d  = 1'b0;
        err_d   = err_q;
        rd      = rail_decode(q0_s, q1_s);

        case (state_q)
            IDLE: begin
                if (bus.req_valid && ready_q) begin
                    dreg_d  = bus.req_data;
                    cnt_d   = SETUP_LD;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    cnt_d   = PULSE_LD;
                    state_d = PULSE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    cnt_d   = HOLD_LD;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    cnt_d   = SETTLE_LD;
                    state_d = SETTLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            CHECK: begin
                state_d = IDLE;
                done_d  = 1'b1;
                err_d   = !rd.valid || (rd.value != dreg_q);
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with the state they describe.
        // dreg only moves on acceptance (lat_e is low then), so lat_d can never change under a pulse.
        lat_d_d = dreg_d;
        lat_e_d = (state_d == PULSE);
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dreg_q  <= 1'b0;
            lat_d_q <= 1'b0;
            lat_e_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dreg_q  <= dreg_d;
            lat_d_q <= lat_d_d;
            lat_e_q <= lat_e_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.lat_d     = lat_d_q;
    assign bus.lat_e     = lat_e_q;
    assign bus.req_ready = ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_latch_write_ctrl.sv
// tb/tb_latch_write_ctrl.sv - directed self-checking bench for latch_write_ctrl
module tb_latch_write_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    // 0: correct latch, 1: q0 stuck at 1, 2: both rails forced high
    int   fault = 0;
    logic stored = 1'b0;

    latch_write_ctrl_if bus ();

    latch_write_ctrl dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Behavioural gated D-latch with fault injection on its outputs.
    always @(bus.lat_e or bus.lat_d) begin
        if (bus.lat_e) stored = bus.lat_d;
    end

    always_comb begin
        bus.lat_q0 = (fault != 0) ? 1'b1 : stored;
        bus.lat_q1 = (fault == 2) ? 1'b1 : ~stored;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request and checks every cycle until done against the fixed 13-cycle timeline.
    task automatic run_write(input logic data, input logic exp_err, input bit toggle, input string name);
        logic exp_e;
        bit   got_done;
        got_done = 0;
        for (int i = 0; i < 20 && bus.req_ready !== 1'b1; i++) step();
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready_wait: got %b want 1", name, bus.req_ready);
        end
        bus.req_valid = 1'b1;
        bus.req_data  = data;
        step();
        bus.req_valid = 1'b0;
        for (int n = 1; n <= 13; n++) begin
            if (toggle && n <= 8) bus.req_data = ~bus.req_data;
            exp_e = (n >= 3 && n <= 6);
            n_checks++;
            if (bus.lat_e !== exp_e) begin
                n_fail++;
                $display("FAIL %s lat_e cyc%0d: got %b want %b", name, n, bus.lat_e, exp_e);
            end
            n_checks++;
            if (bus.lat_d !== data) begin
                n_fail++;
                $display("FAIL %s lat_d cyc%0d: got %b want %b", name, n, bus.lat_d, data);
            end
            if (n < 13) begin
                n_checks++;
                if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.req_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s status cyc%0d: got done=%b busy=%b ready=%b want 0 1 0",
                             name, n, bus.done, bus.busy, bus.req_ready);
                end
                step();
            end else begin
                got_done = 1;
                n_checks++;
                if (bus.done !== 1'b1 || bus.err !== exp_err || bus.req_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s done_cyc13: got done=%b err=%b ready=%b want 1 %b 1",
                             name, bus.done, bus.err, bus.req_ready, exp_err);
                end
            end
        end
        step();
        n_checks++;
        if (bus.done !== 1'b0 || bus.err !== exp_err) begin
            n_fail++;
            $display("FAIL %s after_done: got done=%b err=%b want 0 %b", name, bus.done, bus.err, exp_err);
        end
        bus.req_data = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_data  = 1'b0;
        step();
        step();
        n_checks++;
        if ({bus.lat_d, bus.lat_e, bus.req_ready, bus.busy, bus.done, bus.err} !== 6'b001000) begin
            n_fail++;
            $display("FAIL reset_state: got d,e,rdy,busy,done,err=%b want 001000",
                     {bus.lat_d, bus.lat_e, bus.req_ready, bus.busy, bus.done, bus.err});
        end
        #3 rst_n = 1'b1;
        step();
    endtask

    task automatic test_write_one();
        fault = 0;
        run_write(1'b1, 1'b0, 0, "write_one");
    endtask

    task automatic test_write_zero();
        fault = 0;
        run_write(1'b0, 1'b0, 0, "write_zero");
        n_checks++;
        if (bus.lat_q0 !== 1'b0 || bus.lat_q1 !== 1'b1) begin
            n_fail++;
            $display("FAIL write_zero rails: got q0=%b q1=%b want 0 1", bus.lat_q0, bus.lat_q1);
        end
    endtask

    task automatic test_faults();
        fault = 1;
        run_write(1'b0, 1'b1, 0, "stuck_q0");
        fault = 2;
        run_write(1'b1, 1'b1, 0, "both_high");
        fault = 0;
        run_write(1'b1, 1'b0, 0, "recover");
    endtask

    task automatic test_toggle();
        fault = 0;
        run_write(1'b0, 1'b0, 1, "toggle_d0");
        run_write(1'b1, 1'b0, 1, "toggle_d1");
    endtask

    task automatic test_back_to_back();
        logic seq [3];
        logic prev_d, prev_e;
        int   wnum;
        seq[0] = 1'b1; seq[1] = 1'b0; seq[2] = 1'b1;
        wnum = 0;
        fault = 0;
        for (int i = 0; i < 20 && bus.req_ready !== 1'b1; i++) step();
        bus.req_valid = 1'b1;
        bus.req_data  = seq[0];
        prev_d = bus.lat_d;
        prev_e = bus.lat_e;
        step();
        for (int cyc = 1; cyc <= 45 && wnum < 3; cyc++) begin
            n_checks++;
            if (bus.lat_d !== prev_d && (bus.lat_e === 1'b1 || prev_e === 1'b1 || bus.lat_e !== prev_e)) begin
                n_fail++;
                $display("FAIL b2b glitch cyc%0d: got d %b->%b e %b->%b want d stable around e",
                         cyc, prev_d, bus.lat_d, prev_e, bus.lat_e);
            end
            if (cyc % 13 == 1) begin
                n_checks++;
                if (bus.lat_d !== seq[wnum]) begin
                    n_fail++;
                    $display("FAIL b2b lat_d cyc%0d: got %b want %b", cyc, bus.lat_d, seq[wnum]);
                end
            end
            if (bus.done === 1'b1) begin
                n_checks++;
                if (cyc != 13 * (wnum + 1) || bus.err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b done: got cyc%0d err=%b want cyc%0d err=0", cyc, bus.err, 13 * (wnum + 1));
                end
                wnum++;
                if (wnum < 3) bus.req_data = seq[wnum];
                else bus.req_valid = 1'b0;
            end
            prev_d = bus.lat_d;
            prev_e = bus.lat_e;
            step();
        end
        bus.req_valid = 1'b0;
        n_checks++;
        if (wnum != 3) begin
            n_fail++;
            $display("FAIL b2b count: got %0d writes want 3", wnum);
        end
        n_checks++;
        if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b idle: got busy=%b ready=%b want 0 1", bus.busy, bus.req_ready);
        end
    endtask

    task automatic test_reset_mid_pulse();
        bit saw_done;
        saw_done = 0;
        fault = 0;
        for (int i = 0; i < 20 && bus.req_ready !== 1'b1; i++) step();
        bus.req_valid = 1'b1;
        bus.req_data  = 1'b1;
        step();
        bus.req_valid = 1'b0;
        step(); step(); step();
        n_checks++;
        if (bus.lat_e !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pulse pre: got lat_e=%b want 1", bus.lat_e);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.lat_e !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 1'b1 || bus.lat_d !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_pulse async: got e=%b busy=%b ready=%b d=%b want 0 0 1 0",
                     bus.lat_e, bus.busy, bus.req_ready, bus.lat_d);
        end
        step(); step();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.done === 1'b1) saw_done = 1;
        end
        n_checks++;
        if (saw_done) begin
            n_fail++;
            $display("FAIL rst_pulse done: got done pulse want none");
        end
        n_checks++;
        if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0 || bus.lat_e !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_pulse idle: got ready=%b busy=%b e=%b want 1 0 0",
                     bus.req_ready, bus.busy, bus.lat_e);
        end
    endtask

    initial begin
        test_reset();
        test_write_one();
        test_write_zero();
        test_faults();
        test_back_to_back();
        test_reset_mid_pulse();
        test_toggle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
